// File: rtl/board_pkg.sv
// Board-level constants shared by the input-conditioning blocks: FSM encodings
// and default timing derived from the 16 MHz board clock.
package board_pkg;

  localparam logic [1:0] RELEASED = 2'd0;
  localparam logic [1:0] PRESSED  = 2'd1;
  localparam logic [1:0] LONG     = 2'd2;

  typedef enum logic [1:0] {
    ST_RELEASED = RELEASED,
    ST_PRESSED  = PRESSED,
    ST_LONG     = LONG
  } btn_state_t;

  localparam int CLK_HZ                = 16_000_000;
  localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 100;  // 10 ms
  localparam int DEF_LONG_PRESS_CYCLES = CLK_HZ;        // 1 s

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: polarity fix, 2-FF sync, counter debounce and a
// press/long-press/release FSM producing registered single-cycle strobes.
module button_conditioner
  import board_pkg::*;
#(
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_held_long
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic p, s2;
  logic [DB_W-1:0] db_cnt, db_cnt_next;
  logic level, level_next;
  logic [HOLD_W-1:0] hold, hold_next;
  btn_state_t state, state_next;
  logic press_next, release_next, long_next, held_next, held;
  logic press_q, release_q, long_q;

  assign p = i_btn_raw ^ ACTIVE_LOW;

  sync_2ff u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (p),
    .q   (s2)
  );

  // Any disagreement shorter than DEBOUNCE_CYCLES restarts from zero.
  always_comb begin
    db_cnt_next = db_cnt;
    level_next  = level;
    if (s2 == level) begin
      db_cnt_next = '0;
    end else if (db_cnt == DB_LAST) begin
      level_next  = s2;
      db_cnt_next = '0;
    end else begin
      db_cnt_next = db_cnt + DB_W'(1);
    end
  end

  // FSM follows level_next so strobes land on the same edge as o_level.
  always_comb begin
    state_next   = state;
    hold_next    = hold;
    held_next    = held;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    case (state)
      ST_RELEASED: begin
        if (level_next) begin
          state_next = ST_PRESSED;
          press_next = 1'b1;
          hold_next  = '0;
        end
      end
      ST_PRESSED: begin
        if (!level_next) begin
          state_next   = ST_RELEASED;
          release_next = 1'b1;
          held_next    = 1'b0;
          hold_next    = '0;
        end else if (hold == HOLD_LAST) begin
          state_next = ST_LONG;
          long_next  = 1'b1;
          held_next  = 1'b1;
        end else begin
          hold_next = hold + HOLD_W'(1);
        end
      end
      ST_LONG: begin
        if (!level_next) begin
          state_next   = ST_RELEASED;
          release_next = 1'b1;
          held_next    = 1'b0;
          hold_next    = '0;
        end
      end
      default: begin
        state_next = ST_RELEASED;
        held_next  = 1'b0;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      db_cnt    <= '0;
      level     <= 1'b0;
      hold      <= '0;
      state     <= ST_RELEASED;
      held      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      db_cnt    <= db_cnt_next;
      level     <= level_next;
      hold      <= hold_next;
      state     <= state_next;
      held      <= held_next;
      press_q   <= press_next;
      release_q <= release_next;
      long_q    <= long_next;
    end
  end

  assign o_level     = level;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_long      = long_q;
  assign o_held_long = held;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10, active-low pin; outputs sampled 1 time unit after posedge.
module tb_button_conditioner;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_btn_raw;
  logic o_level, o_press, o_release, o_long, o_held_long;

  int tests = 0;
  int fails = 0;

  button_conditioner #(
    .ACTIVE_LOW        (1'b1),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (10)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_btn_raw   (i_btn_raw),
    .o_level     (o_level),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_long      (o_long),
    .o_held_long (o_held_long)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic l, input logic p,
                      input logic r, input logic lg, input logic h);
    chk({tag, ".level"},     o_level,     l);
    chk({tag, ".press"},     o_press,     p);
    chk({tag, ".release"},   o_release,   r);
    chk({tag, ".long"},      o_long,      lg);
    chk({tag, ".held_long"}, o_held_long, h);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst     = 1'b1;
    i_btn_raw = 1'b1;
    step(); step();
    outs("reset", 0, 0, 0, 0, 0);

    // Press: raw low just after edge 0, o_level/o_press at edge 6.
    i_rst     = 1'b0;
    i_btn_raw = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      outs("press_wait", 0, 0, 0, 0, 0);
    end
    step(); outs("press_e6", 1, 1, 0, 0, 0);   // P = 6
    step(); outs("press_e7", 1, 0, 0, 0, 0);
    for (int e = 8; e <= 15; e++) begin
      step();
      outs("hold_pre_long", 1, 0, 0, 0, 0);
    end
    step(); outs("long_p10", 1, 0, 0, 1, 1);
    step(); outs("long_p11", 1, 0, 0, 0, 1);
    for (int e = 18; e <= 21; e++) begin
      step();
      outs("long_hold", 1, 0, 0, 0, 1);
    end
    // Release after edge 21 (P+15): o_level falls at edge 27.
    i_btn_raw = 1'b1;
    for (int e = 22; e <= 26; e++) begin
      step();
      outs("release_wait", 1, 0, 0, 0, 1);
    end
    step(); outs("release_e27", 0, 0, 1, 0, 0);
    step(); outs("release_e28", 0, 0, 0, 0, 0);

    // 3-cycle glitch is rejected.
    i_btn_raw = 1'b0;
    step(); step(); step();
    i_btn_raw = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      outs("glitch", 0, 0, 0, 0, 0);
    end

    // Bounce low/high/low; s2 settles at edge 4, press at edge 8.
    i_btn_raw = 1'b0;
    step(); outs("bounce_e1", 0, 0, 0, 0, 0);
    i_btn_raw = 1'b1;
    step(); outs("bounce_e2", 0, 0, 0, 0, 0);
    i_btn_raw = 1'b0;
    for (int e = 3; e <= 7; e++) begin
      step();
      outs("bounce_wait", 0, 0, 0, 0, 0);
    end
    step(); outs("bounce_e8", 1, 1, 0, 0, 0);   // P = 8
    // Raw released after edge P+3 so o_level falls at P+9.
    for (int e = 9; e <= 16; e++) begin
      step();
      outs("short_hold", 1, 0, 0, 0, 0);
      if (e == 11) i_btn_raw = 1'b1;
    end
    step(); outs("short_rel_p9", 0, 0, 1, 0, 0);
    for (int e = 18; e <= 22; e++) begin
      step();
      outs("short_after", 0, 0, 0, 0, 0);
    end

    // Release on the exact long-threshold edge (P+10): release wins.
    i_btn_raw = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    step(); outs("edge_press", 1, 1, 0, 0, 0);  // P = 6
    for (int e = 7; e <= 15; e++) begin
      step();
      outs("edge_hold", 1, 0, 0, 0, 0);
      if (e == 10) i_btn_raw = 1'b1;
    end
    step(); outs("edge_rel_p10", 0, 0, 1, 0, 0);
    step(); outs("edge_after", 0, 0, 0, 0, 0);
    step(); outs("edge_after2", 0, 0, 0, 0, 0);

    // Reset for 2 cycles while in LONG, raw held low throughout.
    i_btn_raw = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    step(); outs("rl_press", 1, 1, 0, 0, 0);    // P = 6
    for (int e = 7; e <= 15; e++) step();
    step(); outs("rl_long", 1, 0, 0, 1, 1);
    step(); step();
    i_rst = 1'b1;
    step(); outs("rl_rst1", 0, 0, 0, 0, 0);
    step(); outs("rl_rst2", 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      outs("rl_post_wait", 0, 0, 0, 0, 0);
    end
    step(); outs("rl_post_press", 1, 1, 0, 0, 0);
    for (int e = 7; e <= 15; e++) begin
      step();
      outs("rl_post_hold", 1, 0, 0, 0, 0);
    end
    step(); outs("rl_post_long", 1, 0, 0, 1, 1);
    step(); outs("rl_post_long2", 1, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
